mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single 4096x8 data memory between the CPU load/store unit (port 0) and the program loader/DMA engine (port 1). It grants at most one access per clock, drives the memory's address/rd/wr/en controls and the bidirectional data bus, and returns registered read data to the winning requester. Fairness is round-robin, and a lock input allows uninterrupted bursts.

## Interface
- AW, 12, address width (matches memory depth 4096)
- DW, 8, data width
- clk  in  1  system clock, rising edge
- resetb  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read; valid with req
- addr0 / addr1  in  AW  access address; valid with req
- wdata0 / wdata1  in  DW  write data; valid with req and we
- lock0 / lock1  in  1  keep ownership after the current access while req stays high
- gnt0 / gnt1  out  1  the access is performed this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata holds read result
- rdata0 / rdata1  out  DW  registered read data
- mem_addr  out  AW  memory address
- mem_data  inout  DW  memory data bus; driven only on write cycles, else high-Z
- mem_rd / mem_wr / mem_en  out  1  memory controls

## Operation
- State is owner ∈ {NONE, P0, P1} plus last_served ∈ {P0, P1}, both registered.
- gntX = (owner == PX) & reqX, combinational. A gnt cycle is one memory access.
- In a gnt cycle:
  - mem_en = 1 and mem_addr = addrX.
  - If weX: mem_wr = 1 and mem_data = wdataX; the memory commits at the closing edge.
  - Else: mem_rd = 1, and mem_data is captured at the closing edge into rdataX.
- With no gnt: mem_en, mem_rd and mem_wr are 0, mem_addr is 0, and mem_data is Z.
- Next owner, evaluated each posedge in priority order:
  1. The current owner keeps ownership if its req and lock are both 1.
  2. Otherwise, if only one req is high, that port wins.
  3. If both reqs are high, the port that is not last_served wins.
  4. If no req is high, owner becomes NONE.
- last_served takes the granted port on every gnt cycle.
- A lock input is ignored on the port that is not the owner.
- Dropping req while owner means no access that cycle; ownership is re-arbitrated at the next edge.
- Ports never see each other's rdata. Only the port that issued the read gets rvalid.
- A write followed by a read to the same address returns the new data, because the memory writes on the edge and reads combinationally.

## Timing
- Reset (asynchronous, resetb = 0): owner = NONE, last_served = P1 (port 0 wins the first tie), rvalid0/1 = 0, rdata0/1 = 0, mem controls 0, mem_data Z, gnt0/1 = 0.
- A write in progress when reset asserts is not committed: mem_en falls immediately.
- Request to grant: req rising before edge n gives gnt in cycle n+1, if the port wins.
- Read latency: rvalidX and rdataX appear the cycle after the gnt cycle. That is 2 cycles from request to data with no contention.
- Sustained throughput is 1 access per cycle:
  - A single continuous requester is granted every cycle.
  - Two non-locked continuous requesters alternate every cycle.
- The requester presents the next access after sampling gnt = 1 at an edge. Inputs must be stable for the whole gnt cycle (registered at the source).
- rdataX holds its value until the next read by that port.

## Structure
- Shared package noobs_mem_pkg holds:
  - MEM_AW = 12 and MEM_DW = 8
  - owner encoding OWN_NONE = 2'b00, OWN_P0 = 2'b01, OWN_P1 = 2'b10
- Sub-module mem_arb_pick: pure combinational next-owner logic. Inputs are req, lock, owner and last_served; output is next_owner. It is reused by later N-port variants.
- The top level holds the state registers, the memory-side mux, the tristate driver and the read-data capture.

## Test plan
- Reset mid-write: resetb low during a port 1 gnt on write 0x5A to 0x010 -> mem_en drops at once; 0x010 is unchanged; all outputs at reset values.
- Single read: port 0 reads 0x123 preloaded with 0xA5 -> gnt0 in cycle 1; rvalid0 = 1 with rdata0 = 0xA5 in cycle 2; gnt1 = 0 throughout.
- Contention: both ports request continuously from reset -> grants go P0, P1, P0, P1; each port's rvalid follows its own gnt by 1 cycle.
- Lock burst: port 1 is owner with lock1 = 1 and writes 4 bytes 0x01..0x04 to 0xFFC..0xFFF while req0 = 1 -> four consecutive gnt1; gnt0 comes the cycle after lock1 drops.
- Write-then-read: port 0 writes 0x3C to 0x7FF, then reads 0x7FF -> rdata0 = 0x3C.
- Bus hygiene: an idle cycle and all read cycles -> mem_data is Z from the arbiter and mem_wr = 0; on a write cycle mem_data equals wdata.

Source files
------------

// File: rtl/noobs_mem_pkg.sv
// noobs_mem_pkg: shared memory geometry and arbiter owner encoding
package noobs_mem_pkg;
  localparam int MEM_AW = 12;
  localparam int MEM_DW = 8;
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_P0   = 2'b01,
    OWN_P1   = 2'b10
  } owner_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational next-owner choice (lock hold, single winner, round-robin tie)
module mem_arb_pick
  import noobs_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] lock,
  input  logic [1:0] owner,
  input  logic [1:0] last_served,
  output logic [1:0] next_owner
);
  logic keep;
  assign keep = (owner == OWN_P0 && req[0] && lock[0]) || (owner == OWN_P1 && req[1] && lock[1]);
  assign next_owner = keep ? owner
                    : &req ? (last_served == OWN_P0 ? OWN_P1 : OWN_P0)
                    : req[0] ? OWN_P0
                    : req[1] ? OWN_P1
                    : OWN_NONE;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter with lock for a shared single-port memory
module mem_arbiter
  import noobs_mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  inout  wire  [DW-1:0] mem_data,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          mem_en
);
  owner_t        owner, last_served, served_now;
  logic [1:0]    next_owner;
  logic          rd0, rd1;
  logic [DW-1:0] wdata;
  assign gnt0 = owner == OWN_P0 && req0;
  assign gnt1 = owner == OWN_P1 && req1;
  assign mem_en = gnt0 | gnt1;
  assign mem_wr = gnt0 ? we0 : gnt1 & we1;
  assign mem_rd = mem_en & ~mem_wr;
  assign mem_addr = gnt0 ? addr0 : gnt1 ? addr1 : '0;
  assign wdata = gnt0 ? wdata0 : wdata1;
  assign mem_data = mem_wr ? wdata : 'z;
  assign rd0 = gnt0 & ~we0;
  assign rd1 = gnt1 & ~we1;
  // the grant happening now counts as served so back-to-back ties alternate
  assign served_now = gnt0 ? OWN_P0 : gnt1 ? OWN_P1 : last_served;
  mem_arb_pick u_pick (
    .req        ({req1, req0}),
    .lock       ({lock1, lock0}),
    .owner      (owner),
    .last_served(served_now),
    .next_owner (next_owner)
  );
  // ownership state and per-port read capture from the shared bus
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      owner       <= OWN_NONE;
      last_served <= OWN_P1;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      owner       <= owner_t'(next_owner);
      last_served <= served_now;
      rvalid0     <= rd0;
      rvalid1     <= rd1;
      if (rd0) rdata0 <= mem_data;
      if (rd1) rdata1 <= mem_data;
    end
  end
endmodule
